// File: rtl/exec_ctrl_mem_core.sv
// Decode, ALU and word-indexed data memory slice of a single-cycle MIPS-subset CPU.
// Optional macro ALU_OVF_TRAP_EN: signed overflow on add/sub/addi raises ovf and suppresses wreg.
module exec_ctrl_mem_core #(
    parameter int MEM_AW = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        wreg,
    output logic [4:0]  dest_reg,
    output logic [31:0] wb_data,
    output logic        m2reg,
    output logic        wmem,
    output logic [3:0]  aluc,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        branch,
    output logic        jump,
    output logic [27:0] jump_addr,
    output logic [31:0] ext_imm,
    output logic [31:0] mem_rdata,
    output logic        ovf
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_LUI = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9
    } aluc_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [5:0]  opField;
    logic [5:0]  functField;
    logic [4:0]  rtField;
    logic [4:0]  rdField;
    logic [4:0]  saField;
    logic [15:0] immField;

    assign opField    = instr[31:26];
    assign rtField    = instr[20:16];
    assign rdField    = instr[15:11];
    assign saField    = instr[10:6];
    assign functField = instr[5:0];
    assign immField   = instr[15:0];

    aluc_e       aluSel;
    logic        regWrite;
    logic        useImm;
    logic        useShamt;
    logic        signExt;
    logic        isBeq;
    logic        isBne;
    logic        ovfEligible;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [31:0] aluY;
    logic        rawOvf;

    logic [MEM_AW-1:0] memAddr;
    logic [31:0]       mem_q [2**MEM_AW];

    // Anything not matched below stays at the safe defaults: no writes, no branch/jump, ADD.
    always_comb begin
        aluSel      = ALU_ADD;
        regWrite    = 1'b0;
        m2reg       = 1'b0;
        wmem        = 1'b0;
        jump        = 1'b0;
        useImm      = 1'b0;
        useShamt    = 1'b0;
        signExt     = 1'b1;
        isBeq       = 1'b0;
        isBne       = 1'b0;
        ovfEligible = 1'b0;
        case (opField)
            OP_RTYPE: begin
                case (functField)
                    FN_ADD: begin
                        regWrite    = 1'b1;
                        ovfEligible = 1'b1;
                    end
                    FN_SUB: begin
                        aluSel      = ALU_SUB;
                        regWrite    = 1'b1;
                        ovfEligible = 1'b1;
                    end
                    FN_AND: begin
                        aluSel   = ALU_AND;
                        regWrite = 1'b1;
                    end
                    FN_OR: begin
                        aluSel   = ALU_OR;
                        regWrite = 1'b1;
                    end
                    FN_XOR: begin
                        aluSel   = ALU_XOR;
                        regWrite = 1'b1;
                    end
                    FN_SLT: begin
                        aluSel   = ALU_SLT;
                        regWrite = 1'b1;
                    end
                    FN_SLL: begin
                        aluSel   = ALU_SLL;
                        useShamt = 1'b1;
                        regWrite = 1'b1;
                    end
                    FN_SRL: begin
                        aluSel   = ALU_SRL;
                        useShamt = 1'b1;
                        regWrite = 1'b1;
                    end
                    FN_SRA: begin
                        aluSel   = ALU_SRA;
                        useShamt = 1'b1;
                        regWrite = 1'b1;
                    end
                    default: begin
                        aluSel = ALU_ADD;
                    end
                endcase
            end
            OP_ADDI: begin
                regWrite    = 1'b1;
                useImm      = 1'b1;
                ovfEligible = 1'b1;
            end
            OP_SLTI: begin
                aluSel   = ALU_SLT;
                regWrite = 1'b1;
                useImm   = 1'b1;
            end
            OP_ANDI: begin
                aluSel   = ALU_AND;
                regWrite = 1'b1;
                useImm   = 1'b1;
                signExt  = 1'b0;
            end
            OP_ORI: begin
                aluSel   = ALU_OR;
                regWrite = 1'b1;
                useImm   = 1'b1;
                signExt  = 1'b0;
            end
            OP_XORI: begin
                aluSel   = ALU_XOR;
                regWrite = 1'b1;
                useImm   = 1'b1;
                signExt  = 1'b0;
            end
            OP_LUI: begin
                aluSel   = ALU_LUI;
                regWrite = 1'b1;
                useImm   = 1'b1;
                signExt  = 1'b0;
            end
            OP_LW: begin
                regWrite = 1'b1;
                m2reg    = 1'b1;
                useImm   = 1'b1;
            end
            OP_SW: begin
                wmem   = 1'b1;
                useImm = 1'b1;
            end
            OP_BEQ: begin
                aluSel = ALU_SUB;
                isBeq  = 1'b1;
            end
            OP_BNE: begin
                aluSel = ALU_SUB;
                isBne  = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: begin
                aluSel = ALU_ADD;
            end
        endcase
    end

    assign ext_imm = signExt ? {{16{immField[15]}}, immField} : {16'h0000, immField};
    assign aluA    = useShamt ? {27'd0, saField} : rs_val;
    assign aluB    = useImm ? ext_imm : rt_val;
    assign aluc    = aluSel;

    // Shifts always move operand B by A[4:0]; for R-type shifts A carries the sa field.
    always_comb begin
        aluY = 32'h0000_0000;
        case (aluSel)
            ALU_ADD: aluY = aluA + aluB;
            ALU_SUB: aluY = aluA - aluB;
            ALU_AND: aluY = aluA & aluB;
            ALU_OR:  aluY = aluA | aluB;
            ALU_XOR: aluY = aluA ^ aluB;
            ALU_LUI: aluY = {aluB[15:0], 16'h0000};
            ALU_SLT: aluY = {31'd0, ($signed(aluA) < $signed(aluB))};
            ALU_SLL: aluY = aluB << aluA[4:0];
            ALU_SRL: aluY = aluB >> aluA[4:0];
            ALU_SRA: aluY = $unsigned($signed(aluB) >>> aluA[4:0]);
            default: aluY = 32'h0000_0000;
        endcase
    end

    assign alu_result = aluY;
    assign zero       = (aluY == 32'h0000_0000);
    assign branch     = (isBeq & zero) | (isBne & ~zero);
    assign dest_reg   = (opField == OP_RTYPE) ? rdField : rtField;
    assign jump_addr  = {instr[25:0], 2'b00};

    assign rawOvf = (aluSel == ALU_SUB)
                  ? ((aluA[31] != aluB[31]) && (aluY[31] != aluA[31]))
                  : ((aluA[31] == aluB[31]) && (aluY[31] != aluA[31]));

`ifdef ALU_OVF_TRAP_EN
    assign ovf = ovfEligible & rawOvf;
`else
    logic unusedOvfSink;
    assign unusedOvfSink = ovfEligible ^ rawOvf;
    assign ovf           = 1'b0;
`endif

    assign wreg = regWrite & ~ovf;

    assign memAddr   = aluY[MEM_AW-1:0];
    assign mem_rdata = mem_q[memAddr];
    assign wb_data   = m2reg ? mem_rdata : aluY;

    // Reset wipes the whole array and takes priority over a store in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**MEM_AW; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (wmem) begin
            mem_q[memAddr] <= rt_val;
        end
    end

endmodule

// File: tb/tb_exec_ctrl_mem_core.sv
// Self-checking bench for exec_ctrl_mem_core: directed scenarios plus randomized
// instructions checked against an instruction-level reference model.
module tb_exec_ctrl_mem_core;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        wreg;
    logic [4:0]  dest_reg;
    logic [31:0] wb_data;
    logic        m2reg;
    logic        wmem;
    logic [3:0]  aluc;
    logic [31:0] alu_result;
    logic        zero;
    logic        branch;
    logic        jump;
    logic [27:0] jump_addr;
    logic [31:0] ext_imm;
    logic [31:0] mem_rdata;
    logic        ovf;

    exec_ctrl_mem_core #(.MEM_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .wreg       (wreg),
        .dest_reg   (dest_reg),
        .wb_data    (wb_data),
        .m2reg      (m2reg),
        .wmem       (wmem),
        .aluc       (aluc),
        .alu_result (alu_result),
        .zero       (zero),
        .branch     (branch),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .ext_imm    (ext_imm),
        .mem_rdata  (mem_rdata),
        .ovf        (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] modelMem [32];

    logic [5:0] rFuncts [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02, 6'h03};
    logic [5:0] iOps [10]   = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};

    typedef struct packed {
        logic        resKnown;
        logic        extKnown;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        branch;
        logic        jump;
        logic        ovf;
        logic [3:0]  aluc;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] ext;
    } exp_t;

    // Instruction-level model: what each mnemonic should produce.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sa;
        logic [15:0] imm;
        logic [31:0] sx;
        logic [31:0] zx;
        logic        over;
        op   = ins[31:26];
        fn   = ins[5:0];
        sa   = ins[10:6];
        imm  = ins[15:0];
        sx   = {{16{imm[15]}}, imm};
        zx   = {16'h0000, imm};
        over = 1'b0;
        e    = '0;
        e.resKnown = 1'b1;
        e.dest     = (op == 6'h00) ? ins[15:11] : ins[20:16];
        case (op)
            6'h00: begin
                e.wreg = 1'b1;
                case (fn)
                    6'h20: begin e.result = rs + rt; over = (rs[31] == rt[31]) && (e.result[31] != rs[31]); end
                    6'h22: begin e.result = rs - rt; e.aluc = 4'd1; over = (rs[31] != rt[31]) && (e.result[31] != rs[31]); end
                    6'h24: begin e.result = rs & rt; e.aluc = 4'd2; end
                    6'h25: begin e.result = rs | rt; e.aluc = 4'd3; end
                    6'h26: begin e.result = rs ^ rt; e.aluc = 4'd4; end
                    6'h2A: begin e.result = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; e.aluc = 4'd6; end
                    6'h00: begin e.result = rt << sa; e.aluc = 4'd7; end
                    6'h02: begin e.result = rt >> sa; e.aluc = 4'd8; end
                    6'h03: begin e.result = $unsigned($signed(rt) >>> sa); e.aluc = 4'd9; end
                    default: begin e.wreg = 1'b0; e.resKnown = 1'b0; end
                endcase
            end
            6'h08: begin e.wreg = 1'b1; e.result = rs + sx; e.ext = sx; e.extKnown = 1'b1;
                         over = (rs[31] == sx[31]) && (e.result[31] != rs[31]); end
            6'h0A: begin e.wreg = 1'b1; e.aluc = 4'd6; e.ext = sx; e.extKnown = 1'b1;
                         e.result = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; end
            6'h0C: begin e.wreg = 1'b1; e.aluc = 4'd2; e.result = rs & zx; e.ext = zx; e.extKnown = 1'b1; end
            6'h0D: begin e.wreg = 1'b1; e.aluc = 4'd3; e.result = rs | zx; e.ext = zx; e.extKnown = 1'b1; end
            6'h0E: begin e.wreg = 1'b1; e.aluc = 4'd4; e.result = rs ^ zx; e.ext = zx; e.extKnown = 1'b1; end
            6'h0F: begin e.wreg = 1'b1; e.aluc = 4'd5; e.result = {imm, 16'h0000}; end
            6'h23: begin e.wreg = 1'b1; e.m2reg = 1'b1; e.result = rs + sx; e.ext = sx; e.extKnown = 1'b1; end
            6'h2B: begin e.wmem = 1'b1; e.result = rs + sx; e.ext = sx; e.extKnown = 1'b1; end
            6'h04: begin e.aluc = 4'd1; e.result = rs - rt; e.branch = (rs == rt); e.ext = sx; e.extKnown = 1'b1; end
            6'h05: begin e.aluc = 4'd1; e.result = rs - rt; e.branch = (rs != rt); e.ext = sx; e.extKnown = 1'b1; end
            6'h02: begin e.jump = 1'b1; e.resKnown = 1'b0; end
            default: e.resKnown = 1'b0;
        endcase
`ifdef ALU_OVF_TRAP_EN
        if (over) begin
            e.ovf  = 1'b1;
            e.wreg = 1'b0;
        end
`endif
        return e;
    endfunction

    function automatic logic [31:0] rInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sa, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] iInstr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        instr  = ins;
        rs_val = a;
        rt_val = b;
        #1;
    endtask

    // Advance one clock, mirroring the expected memory effect of the cycle into the model.
    task automatic endCycle(input logic doWrite, input logic [4:0] addr, input logic [31:0] data);
        if (rst) begin
            for (int i = 0; i < 32; i++) modelMem[i] = 32'h0;
        end else if (doWrite) begin
            modelMem[addr] = data;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(iInstr(6'h2B, 5'd0, 5'd1, 16'd5), 32'd0, 32'hFFFF_FFFF);
        endCycle(1'b1, 5'd5, 32'hFFFF_FFFF);
        endCycle(1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(iInstr(6'h23, 5'd0, 5'd2, 16'(i)), 32'd0, 32'd0);
            checks++;
            if (mem_rdata !== 32'h0 || wb_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_clear addr=%0d got rdata=%h wb=%h exp=0", i, mem_rdata, wb_data);
            end
            endCycle(1'b0, 5'd0, 32'd0);
        end
    endtask

    task automatic test_alu_ops();
        applyStimulus(rInstr(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd1, 32'd3);
        checks++;
        if (alu_result !== 32'd4 || wreg !== 1'b1 || dest_reg !== 5'd3) begin
            errors++;
            $display("FAIL add got res=%h wreg=%b dest=%0d exp res=4 wreg=1 dest=3", alu_result, wreg, dest_reg);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(rInstr(5'd1, 5'd2, 5'd4, 5'd0, 6'h22), 32'd4, 32'd1);
        checks++;
        if (alu_result !== 32'd3 || aluc !== 4'd1) begin
            errors++;
            $display("FAIL sub got res=%h aluc=%0d exp res=3 aluc=1", alu_result, aluc);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(iInstr(6'h0C, 5'd1, 5'd2, 16'h000C), 32'd9, 32'd0);
        checks++;
        if (alu_result !== 32'd8 || dest_reg !== 5'd2 || ext_imm !== 32'h0000_000C) begin
            errors++;
            $display("FAIL andi got res=%h dest=%0d ext=%h exp res=8 dest=2 ext=c", alu_result, dest_reg, ext_imm);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(iInstr(6'h0D, 5'd1, 5'd2, 16'h0007), 32'd8, 32'd0);
        checks++;
        if (alu_result !== 32'd15) begin
            errors++;
            $display("FAIL ori got res=%h exp f", alu_result);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(iInstr(6'h08, 5'd1, 5'd2, 16'hFFFF), 32'd1, 32'd0);
        checks++;
        if (alu_result !== 32'd0 || zero !== 1'b1 || ext_imm !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL addi_neg got res=%h zero=%b ext=%h exp res=0 zero=1 ext=ffffffff", alu_result, zero, ext_imm);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(rInstr(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 32'd0, 32'h8000_0000);
        checks++;
        if (alu_result !== 32'hF800_0000) begin
            errors++;
            $display("FAIL sra got res=%h exp f8000000", alu_result);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(iInstr(6'h0F, 5'd0, 5'd2, 16'h1234), 32'd0, 32'd0);
        checks++;
        if (alu_result !== 32'h1234_0000 || aluc !== 4'd5) begin
            errors++;
            $display("FAIL lui got res=%h aluc=%0d exp res=12340000 aluc=5", alu_result, aluc);
        end
        endCycle(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_mem();
        applyStimulus(iInstr(6'h2B, 5'd0, 5'd1, 16'd1), 32'd0, 32'd1);
        checks++;
        if (wmem !== 1'b1 || wreg !== 1'b0 || alu_result !== 32'd1) begin
            errors++;
            $display("FAIL sw_ctrl got wmem=%b wreg=%b addr=%h exp wmem=1 wreg=0 addr=1", wmem, wreg, alu_result);
        end
        endCycle(1'b1, 5'd1, 32'd1);
        applyStimulus(iInstr(6'h23, 5'd0, 5'd2, 16'd1), 32'd0, 32'd0);
        checks++;
        if (wb_data !== modelMem[1] || m2reg !== 1'b1 || wreg !== 1'b1) begin
            errors++;
            $display("FAIL lw_after_sw got wb=%h m2reg=%b wreg=%b exp wb=%h m2reg=1 wreg=1", wb_data, m2reg, wreg, modelMem[1]);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(iInstr(6'h2B, 5'd0, 5'd1, 16'd1), 32'd0, 32'h0000_DEAD);
        checks++;
        if (mem_rdata !== 32'd1) begin
            errors++;
            $display("FAIL same_cycle_old got rdata=%h exp 1", mem_rdata);
        end
        endCycle(1'b1, 5'd1, 32'h0000_DEAD);
        applyStimulus(iInstr(6'h2B, 5'd0, 5'd1, 16'd0), 32'h0000_0023, 32'h1357_9BDF);
        endCycle(1'b1, 5'd3, 32'h1357_9BDF);
        applyStimulus(iInstr(6'h23, 5'd0, 5'd2, 16'd3), 32'd0, 32'd0);
        checks++;
        if (wb_data !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL addr_wrap got wb=%h exp 13579bdf", wb_data);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        applyStimulus(32'h0, 32'd0, 32'd0);
        endCycle(1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        applyStimulus(iInstr(6'h23, 5'd0, 5'd2, 16'd1), 32'd0, 32'd0);
        checks++;
        if (wb_data !== 32'h0) begin
            errors++;
            $display("FAIL lw_after_rst got wb=%h exp 0", wb_data);
        end
        endCycle(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_compare();
        applyStimulus(rInstr(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'd1, 32'd0);
        checks++;
        if (alu_result !== 32'd0) begin
            errors++;
            $display("FAIL slt_1_0 got res=%h exp 0", alu_result);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(iInstr(6'h0A, 5'd0, 5'd2, 16'd2), 32'd0, 32'd0);
        checks++;
        if (alu_result !== 32'd1 || wreg !== 1'b1) begin
            errors++;
            $display("FAIL slti got res=%h wreg=%b exp res=1 wreg=1", alu_result, wreg);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(rInstr(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (alu_result !== 32'd1) begin
            errors++;
            $display("FAIL slt_signed got res=%h exp 1", alu_result);
        end
        endCycle(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_branch_jump();
        applyStimulus(iInstr(6'h05, 5'd0, 5'd1, 16'd8), 32'd1, 32'd1);
        checks++;
        if (branch !== 1'b0 || wreg !== 1'b0) begin
            errors++;
            $display("FAIL bne_equal got branch=%b wreg=%b exp branch=0 wreg=0", branch, wreg);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus(iInstr(6'h04, 5'd0, 5'd1, 16'd8), 32'd0, 32'd0);
        checks++;
        if (branch !== 1'b1 || aluc !== 4'd1) begin
            errors++;
            $display("FAIL beq_equal got branch=%b aluc=%0d exp branch=1 aluc=1", branch, aluc);
        end
        endCycle(1'b0, 5'd0, 32'd0);
        applyStimulus({6'h02, 26'h10}, 32'd5, 32'd7);
        checks++;
        if (jump !== 1'b1 || jump_addr !== 28'h40 || wmem !== 1'b0 || wreg !== 1'b0) begin
            errors++;
            $display("FAIL jump got jump=%b addr=%h wmem=%b wreg=%b exp 1 40 0 0", jump, jump_addr, wmem, wreg);
        end
        endCycle(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_overflow();
        logic expOvf;
`ifdef ALU_OVF_TRAP_EN
        expOvf = 1'b1;
`else
        expOvf = 1'b0;
`endif
        applyStimulus(rInstr(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'd1);
        checks++;
        if (alu_result !== 32'h8000_0000 || ovf !== expOvf || wreg !== !expOvf) begin
            errors++;
            $display("FAIL add_ovf got res=%h ovf=%b wreg=%b exp res=80000000 ovf=%b wreg=%b",
                     alu_result, ovf, wreg, expOvf, !expOvf);
        end
        endCycle(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_random();
        exp_t        e;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expWb;
        int          k;
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            k   = $urandom_range(0, 20);
            if (k < 9) begin
                ins[31:26] = 6'h00;
                ins[5:0]   = rFuncts[k];
            end else if (k < 19) begin
                ins[31:26] = iOps[k - 9];
            end else if (k == 19) begin
                ins[31:26] = 6'h02;
            end else if ($urandom_range(0, 1) == 0) begin
                ins[31:26] = 6'h00;
                ins[5:0]   = 6'h30 | 6'($urandom_range(0, 7));
            end else begin
                ins[31:26] = 6'h10 | 6'($urandom_range(0, 15));
            end
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            e = model(ins, a, b);
            applyStimulus(ins, a, b);
            checks++;
            if (wreg !== e.wreg || wmem !== e.wmem || m2reg !== e.m2reg) begin
                errors++;
                $display("FAIL rnd_enables #%0d instr=%h got wreg=%b wmem=%b m2reg=%b exp %b %b %b",
                         n, ins, wreg, wmem, m2reg, e.wreg, e.wmem, e.m2reg);
            end
            checks++;
            if (branch !== e.branch || jump !== e.jump || ovf !== e.ovf) begin
                errors++;
                $display("FAIL rnd_flow #%0d instr=%h got branch=%b jump=%b ovf=%b exp %b %b %b",
                         n, ins, branch, jump, ovf, e.branch, e.jump, e.ovf);
            end
            checks++;
            if (aluc !== e.aluc || dest_reg !== e.dest || jump_addr !== {ins[25:0], 2'b00}) begin
                errors++;
                $display("FAIL rnd_decode #%0d instr=%h got aluc=%0d dest=%0d jaddr=%h exp %0d %0d %h",
                         n, ins, aluc, dest_reg, jump_addr, e.aluc, e.dest, {ins[25:0], 2'b00});
            end
            if (e.extKnown) begin
                checks++;
                if (ext_imm !== e.ext) begin
                    errors++;
                    $display("FAIL rnd_ext #%0d instr=%h got %h exp %h", n, ins, ext_imm, e.ext);
                end
            end
            if (e.resKnown) begin
                expWb = e.m2reg ? modelMem[e.result[4:0]] : e.result;
                checks++;
                if (alu_result !== e.result || zero !== (e.result == 32'h0)) begin
                    errors++;
                    $display("FAIL rnd_alu #%0d instr=%h a=%h b=%h got res=%h zero=%b exp res=%h zero=%b",
                             n, ins, a, b, alu_result, zero, e.result, (e.result == 32'h0));
                end
                checks++;
                if (mem_rdata !== modelMem[e.result[4:0]] || wb_data !== expWb) begin
                    errors++;
                    $display("FAIL rnd_mem #%0d instr=%h got rdata=%h wb=%h exp rdata=%h wb=%h",
                             n, ins, mem_rdata, wb_data, modelMem[e.result[4:0]], expWb);
                end
            end
            endCycle(e.wmem, e.result[4:0], b);
        end
    endtask

    initial begin
        rst    = 1'b1;
        instr  = 32'h0;
        rs_val = 32'h0;
        rt_val = 32'h0;
        for (int i = 0; i < 32; i++) modelMem[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_alu_ops();
        test_mem();
        test_compare();
        test_branch_jump();
        test_overflow();
        test_random();
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_ctrl_mem_core.md
Name: exec_ctrl_mem_core

Overview:
- Combined decode/execute/memory slice of a single-cycle MIPS-subset CPU.
- Decodes the current 32-bit instruction into control signals and runs the ALU on register-file operands.
- Accesses a word-indexed data memory and produces the writeback data and branch/jump decisions.
- PC logic, register file and instruction fetch live outside this block.

Parameters:
- MEM_AW, 5, data-memory word-address width; depth = 2**MEM_AW 32-bit words.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- instr  in  32  current instruction: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], funct=[5:0], imm=[15:0], target=[25:0]
- rs_val  in  32  register-file read data for rs
- rt_val  in  32  register-file read data for rt
- wreg  out  1  register write enable
- dest_reg  out  5  write register: rd for R-type, rt otherwise
- wb_data  out  32  mem_rdata when m2reg=1, else alu_result
- m2reg  out  1  load select
- wmem  out  1  memory write enable
- aluc  out  4  ALU operation code
- alu_result  out  32  ALU output; also the memory address
- zero  out  1  alu_result == 0
- branch  out  1  branch taken
- jump  out  1  jump instruction
- jump_addr  out  28  {target, 2'b00}
- ext_imm  out  32  extended immediate
- mem_rdata  out  32  memory read data
- ovf  out  1  overflow trap flag (see Optional Feature)

Behaviour:
- Decode, ALU and memory read are purely combinational; only memory writes and reset are clocked. There are no output registers, so outputs carry no reset value and follow the inputs combinationally.
- R-type, op=0x00. All set wreg=1 and use dest=rd.
  - add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, slt 0x2A use A=rs_val, B=rt_val.
  - sll 0x00, srl 0x02, sra 0x03 use A={27'b0,sa}, B=rt_val; the result is rt shifted by sa.
  - All-zero instr (nop = sll r0) writes r0; the register file ignores r0.
- I-type: all use B=ext_imm and dest=rt.
  - addi 0x08, slti 0x0A: sign-extend.
  - andi 0x0C, ori 0x0D, xori 0x0E: zero-extend.
  - lui 0x0F: result imm<<16.
  - lw 0x23: add, sign-extend, m2reg=1, wreg=1.
  - sw 0x2B: add, sign-extend, wmem=1, wreg=0.
- Branches: beq 0x04 and bne 0x05 use sub with B=rt_val, sign-extend, wreg=0.
  - beq: branch = zero.
  - bne: branch = !zero.
- j 0x02: jump=1; all writes are 0.
- Any undefined op or funct: all enables and branch/jump are 0; aluc=ADD.
- aluc encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 LUI, 0110 SLT, 0111 SLL, 1000 SRL, 1001 SRA
  - Remaining codes return 0.
- ALU arithmetic:
  - Arithmetic is 32-bit wrap-around.
  - SLT is signed compare, result 1 or 0.
  - Shift amount is A[4:0]; SRA is arithmetic.
- Data memory:
  - Address is alu_result[MEM_AW-1:0] as a word index with no byte scaling; upper bits are ignored, so the address wraps.
  - Read is asynchronous.
  - Write occurs on the clk rising edge when wmem=1 and rst=0.
  - A write is visible to a read of the same address after that edge. Same-cycle read returns the old data.
- Reset: on a clk edge with rst=1, all memory words are cleared to 0 and any write in that cycle is dropped.

Optional Feature:
- Macro: ALU_OVF_TRAP_EN.
- Defined:
  - Signed overflow on add, sub or addi forces ovf=1 and wreg=0.
  - Signed overflow is operands of equal sign for add (or opposite sign for sub) giving a result of different sign.
- Undefined: ovf is tied 0 and overflow wraps silently.

Test Plan:
- add: rs_val=1, rt_val=3 -> alu_result=4, wreg=1, dest_reg=rd. sub: rs_val=4, rt_val=1 -> 3.
- andi: 9 & 0x000C -> 8. ori: 8 | 7 -> 15. addi: imm=0xFFFF with rs=1 -> 0, zero=1.
- sw: op 0x2B, rs_val=0, imm=1, rt_val=1 -> mem[1]=1 after the edge. Then lw at the same address -> wb_data=1, m2reg=1. Then rst pulse -> lw reads 0.
- slt: 1 vs 0 -> 0. slti: rs=0, imm=2 -> 1. slt: 0xFFFFFFFF vs 1 -> 1 (signed).
- bne: r0=1, r1=1 -> branch=0. beq: 0 vs 0 -> branch=1. j: target=0x10 -> jump=1, jump_addr=0x40, wmem=0, wreg=0.
- With ALU_OVF_TRAP_EN: add 0x7FFFFFFF+1 -> ovf=1, wreg=0. Without the macro: result 0x80000000, ovf=0.
